// File: rtl/ddc_scale_round_mc_pkg.sv
// rtl/ddc_scale_round_mc_pkg.sv - shared types, constants and helpers for the DDC scale/round back end
package ddc_scale_round_mc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PROC  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Control register: {trunc_mode, chan_en[15:0]} at settings offset NCHAN
  localparam int CTRL_TRUNC_BIT = 16;
  localparam int CTRL_WIDTH     = 17;
  localparam int MAX_CHAN       = 16;

  typedef struct packed {
    logic       valid;
    logic       is_q;
    logic [3:0] chan;
    logic       last;
  } lane_tag_t;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + {4'd0, v[i]};
    return n;
  endfunction

  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ddc_out_fifo.sv
// rtl/ddc_out_fifo.sv - synchronous show-ahead FIFO with registered count and free-space output
module ddc_out_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  output logic [$clog2(DEPTH):0] free
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_wr, do_rd;

  // A pop frees the slot in the same cycle, so a full FIFO still takes a write
  always_comb begin
    do_rd    = rd_en && (count_q != '0);
    do_wr    = wr_en && ((count_q != DEPTH_C) || do_rd);
    wr_ptr_d = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_valid = (count_q != '0);
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign free     = DEPTH_C - count_q;

endmodule

// File: rtl/setting_reg.sv
// rtl/setting_reg.sv - settings-bus register, loads when strobed at its address
module setting_reg #(
  parameter int MY_ADDR = 0,
  parameter int WIDTH   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             strobe,
  input  logic [7:0]       addr,
  input  logic [31:0]      data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] val_q, val_d;
  logic             unused_bits;

  assign unused_bits = ^data_in;

  always_comb begin
    val_d = val_q;
    if (strobe && (addr == 8'(MY_ADDR))) val_d = data_in[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) val_q <= '0;
    else     val_q <= val_d;
  end

  assign data_out = val_q;

endmodule

// File: rtl/ddc_scale_round_mc.sv
// rtl/ddc_scale_round_mc.sv - multi-channel scale/round/saturate back end with shared multiplier and output FIFO
module ddc_scale_round_mc
  import ddc_scale_round_mc_pkg::*;
#(
  parameter int BASE        = 0,
  parameter int NCHAN       = 2,
  parameter int WIDTH_IN    = 24,
  parameter int WIDTH_OUT   = 16,
  parameter int SCALE_WIDTH = 18,
  parameter int SCALE_SHIFT = 22,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      set_stb,
  input  logic [7:0]                set_addr,
  input  logic [31:0]               set_data,
  input  logic [NCHAN*WIDTH_IN-1:0] in_i,
  input  logic [NCHAN*WIDTH_IN-1:0] in_q,
  input  logic                      in_stb,
  input  logic                      run,
  output logic [2*WIDTH_OUT-1:0]    o_tdata,
  output logic [3:0]                o_tchan,
  output logic                      o_tlast,
  output logic                      o_tvalid,
  input  logic                      o_tready,
  output logic                      overflow,
  output logic                      clipped,
  output logic [15:0]               drop_count
);

  localparam int PW = WIDTH_IN + SCALE_WIDTH;
  localparam int FW = $clog2(FIFO_DEPTH) + 1;
  localparam int QW = 2 * WIDTH_OUT + 5;
  localparam logic [15:0]          CHAN_MASK = 16'((32'd1 << NCHAN) - 32'd1);
  localparam logic signed [PW-1:0] RND_BIAS  = PW'(64'sd1 <<< (SCALE_SHIFT - 1));
  localparam logic signed [PW-1:0] SAT_MAX   = PW'((64'sd1 <<< (WIDTH_OUT - 1)) - 64'sd1);
  localparam logic signed [PW-1:0] SAT_MIN   = PW'(-(64'sd1 <<< (WIDTH_OUT - 1)));

  logic                       clear;
  logic [SCALE_WIDTH-1:0]     scale_arr  [MAX_CHAN];
  logic [WIDTH_IN-1:0]        lane_i_arr [MAX_CHAN];
  logic [WIDTH_IN-1:0]        lane_q_arr [MAX_CHAN];
  logic [CTRL_WIDTH-1:0]      ctrl;
  logic [NCHAN*WIDTH_IN-1:0]  samp_i_q, samp_i_d, samp_q_q, samp_q_d;

  assign clear = rst || clr;

  // Unused channel slots read as zero so the 4-bit channel index covers the arrays
  for (genvar c = 0; c < MAX_CHAN; c++) begin : g_chan
    if (c < NCHAN) begin : g_used
      setting_reg #(.MY_ADDR(BASE + c), .WIDTH(SCALE_WIDTH)) u_scale (
        .clk      (clk),
        .rst      (rst),
        .strobe   (set_stb),
        .addr     (set_addr),
        .data_in  (set_data),
        .data_out (scale_arr[c])
      );
      assign lane_i_arr[c] = samp_i_q[c*WIDTH_IN +: WIDTH_IN];
      assign lane_q_arr[c] = samp_q_q[c*WIDTH_IN +: WIDTH_IN];
    end else begin : g_unused
      assign scale_arr[c]  = '0;
      assign lane_i_arr[c] = '0;
      assign lane_q_arr[c] = '0;
    end
  end

  setting_reg #(.MY_ADDR(BASE + NCHAN), .WIDTH(CTRL_WIDTH)) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .strobe   (set_stb),
    .addr     (set_addr),
    .data_in  (set_data),
    .data_out (ctrl)
  );

  logic [15:0]   en_mask;
  logic [4:0]    en_count;
  logic [FW-1:0] fifo_free;
  logic          stb_valid, fits, accept, drop, issue;

  assign en_mask   = ctrl[15:0] & CHAN_MASK;
  assign en_count  = popcount16(en_mask);
  assign stb_valid = in_stb && run && (en_count != 5'd0);
  assign fits      = 32'(fifo_free) >= 32'(en_count);

  state_t      state_q, state_d;
  logic [15:0] rem_q, rem_d;
  logic        lane_q, lane_d, trunc_q, trunc_d, drain_q, drain_d;
  logic [3:0]  cur_chan;
  logic        cur_last;

  assign cur_chan = lowest_set(rem_q);
  assign cur_last = ((rem_q & (rem_q - 16'd1)) == 16'd0);

  always_ff @(posedge clk) begin
    if (clear) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (stb_valid && fits) state_d = ST_PROC;
      ST_PROC:  if (lane_q && cur_last) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_q) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    accept = (state_q == ST_IDLE) && stb_valid && fits;
    drop   = stb_valid && !accept;
    issue  = (state_q == ST_PROC);
  end

  // rem_q holds the enabled channels still to be issued; lowest bit is served next
  always_comb begin
    samp_i_d = samp_i_q;
    samp_q_d = samp_q_q;
    rem_d    = rem_q;
    lane_d   = lane_q;
    trunc_d  = trunc_q;
    drain_d  = 1'b0;
    if (accept) begin
      samp_i_d = in_i;
      samp_q_d = in_q;
      rem_d    = en_mask;
      lane_d   = 1'b0;
      trunc_d  = ctrl[CTRL_TRUNC_BIT];
    end
    if (issue) begin
      lane_d = !lane_q;
      if (lane_q) rem_d = rem_q & ~(16'd1 << cur_chan);
    end
    if (state_q == ST_DRAIN) drain_d = !drain_q;
  end

  lane_tag_t                s1_q, s1_d, s2_q, s2_d;
  logic signed [WIDTH_IN-1:0]    x_mux;
  logic signed [SCALE_WIDTH-1:0] k_mux;
  logic signed [PW-1:0]     p_q, p_d, biased, shifted;
  logic [WIDTH_OUT-1:0]     r_q, r_d, i_hold_q, i_hold_d;
  logic                     sat;

  always_comb begin
    x_mux = lane_q ? lane_q_arr[cur_chan] : lane_i_arr[cur_chan];
    k_mux = scale_arr[cur_chan];
    p_d   = PW'(x_mux) * PW'(k_mux);
    s1_d  = '{valid: issue, is_q: lane_q, chan: cur_chan, last: cur_last};
  end

  always_comb begin
    biased  = trunc_q ? p_q : p_q + RND_BIAS;
    shifted = biased >>> SCALE_SHIFT;
    sat     = 1'b0;
    if (shifted > SAT_MAX) begin
      r_d = SAT_MAX[WIDTH_OUT-1:0];
      sat = 1'b1;
    end else if (shifted < SAT_MIN) begin
      r_d = SAT_MIN[WIDTH_OUT-1:0];
      sat = 1'b1;
    end else begin
      r_d = shifted[WIDTH_OUT-1:0];
    end
    s2_d     = s1_q;
    i_hold_d = (s2_q.valid && !s2_q.is_q) ? r_q : i_hold_q;
  end

  logic        overflow_q, overflow_d, clipped_q, clipped_d;
  logic [15:0] drop_count_q, drop_count_d;

  always_comb begin
    overflow_d   = overflow_q || drop;
    clipped_d    = clipped_q || (sat && s1_q.valid);
    drop_count_d = drop_count_q;
    if (drop && (drop_count_q != 16'hFFFF)) drop_count_d = drop_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    samp_i_q <= samp_i_d;
    samp_q_q <= samp_q_d;
    p_q      <= p_d;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      rem_q        <= '0;
      lane_q       <= 1'b0;
      trunc_q      <= 1'b0;
      drain_q      <= 1'b0;
      s1_q         <= '0;
      s2_q         <= '0;
      r_q          <= '0;
      i_hold_q     <= '0;
      overflow_q   <= 1'b0;
      clipped_q    <= 1'b0;
      drop_count_q <= '0;
    end else begin
      rem_q        <= rem_d;
      lane_q       <= lane_d;
      trunc_q      <= trunc_d;
      drain_q      <= drain_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      r_q          <= r_d;
      i_hold_q     <= i_hold_d;
      overflow_q   <= overflow_d;
      clipped_q    <= clipped_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Beat is complete once the Q result of a channel leaves the round/saturate stage
  logic          fifo_wr;
  logic [QW-1:0] fifo_wdata, fifo_rdata;

  assign fifo_wr    = s2_q.valid && s2_q.is_q;
  assign fifo_wdata = {i_hold_q, r_q, s2_q.chan, s2_q.last};

  ddc_out_fifo #(.WIDTH(QW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .clr      (clear),
    .wr_en    (fifo_wr),
    .wr_data  (fifo_wdata),
    .rd_en    (o_tready),
    .rd_data  (fifo_rdata),
    .rd_valid (o_tvalid),
    .free     (fifo_free)
  );

  assign o_tdata    = fifo_rdata[QW-1:5];
  assign o_tchan    = fifo_rdata[4:1];
  assign o_tlast    = fifo_rdata[0];
  assign overflow   = overflow_q;
  assign clipped    = clipped_q;
  assign drop_count = drop_count_q;

endmodule
